// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
// State encoding, wait-state limits and address alignment mask.
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RDATA  = 3'd3,
        ST_RESP   = 3'd4,
        ST_DRAIN  = 3'd5
    } mem_access_state_t;

    localparam int WAIT_STATES_MAX = 15;
    localparam int WAIT_CNT_W = $clog2(WAIT_STATES_MAX + 1);

    localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Loadable down-counter used to time the wait states before an access.
// "last" is high while the count equals one.
module mem_wait_counter
    import mem_access_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  clrN,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] loadVal,
    input  logic                  dec,
    output logic                  last
);

    logic [WAIT_CNT_W-1:0] count;

    // Synchronous clear has priority over load, load over decrement.
    always_ff @(posedge clk) begin
        if (!clrN) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == WAIT_CNT_W'(1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Bus-side controller between the RD/WR/ACK handshake and the word RAM.
// One RAM access per request, with programmable wait states.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32,
    parameter int ADDRWIDTH     = 10,
    parameter int WAIT_STATES   = 2
)(
    input  logic                     MEM_ACCESS_CTRL_CLOCK_50,
    input  logic                     MEM_ACCESS_CTRL_RESET_InLow,
    input  logic                     MEM_ACCESS_CTRL_RD_In,
    input  logic                     MEM_ACCESS_CTRL_WR_In,
    input  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_ADDRESS_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_data_InBUS,
    output logic                     MEM_ACCESS_CTRL_ACK_Out,
    output logic                     MEM_ACCESS_CTRL_ERROR_Out,
    output logic                     MEM_ACCESS_CTRL_BUSY_Out,
    output logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_data_OutBUS,
    output logic                     MEM_ACCESS_CTRL_MEM_EN_Out,
    output logic                     MEM_ACCESS_CTRL_MEM_WE_Out,
    output logic [ADDRWIDTH-1:0]     MEM_ACCESS_CTRL_MEM_ADDR_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_MEM_WDATA_OutBUS,
    input  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_MEM_RDATA_InBUS
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
    localparam bit NO_WAIT = (WAIT_STATES == 0);

    logic clk;
    logic rstN;
    logic req;
    logic reqErr;
    logic misaligned;
    logic outOfRange;
    logic waitLoad;
    logic waitDec;
    logic waitLast;
    logic sampleReq;

    mem_access_state_t state;
    mem_access_state_t stateNext;

    logic [ADDRWIDTH-1:0]     addrLatch;
    logic [DATAWIDTH_BUS-1:0] wdataLatch;
    logic                     opWrite;
    logic                     errLatch;
    logic [DATAWIDTH_BUS-1:0] readData;

    assign clk  = MEM_ACCESS_CTRL_CLOCK_50;
    assign rstN = MEM_ACCESS_CTRL_RESET_InLow;
    assign req  = MEM_ACCESS_CTRL_RD_In | MEM_ACCESS_CTRL_WR_In;

    assign misaligned =
        |(MEM_ACCESS_CTRL_ADDRESS_InBUS[1:0] & ADDR_ALIGN_MASK);
    assign outOfRange =
        (MEM_ACCESS_CTRL_ADDRESS_InBUS >> (ADDRWIDTH + 2)) != '0;
    assign reqErr = (MEM_ACCESS_CTRL_RD_In & MEM_ACCESS_CTRL_WR_In)
                  | misaligned | outOfRange;

    assign sampleReq = (state == ST_IDLE) && req;
    assign waitLoad  = sampleReq && !reqErr;
    assign waitDec   = (state == ST_WAIT) && !waitLast;

    mem_wait_counter u_waitCnt (
        .clk     (clk),
        .clrN    (rstN),
        .load    (waitLoad),
        .loadVal (WAIT_LOAD),
        .dec     (waitDec),
        .last    (waitLast)
    );

    // Next-state decode; requests are only looked at in IDLE and DRAIN.
    always_comb begin
        stateNext = state;
        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    if (reqErr) begin
                        stateNext = ST_RESP;
                    end else if (NO_WAIT) begin
                        stateNext = ST_ACCESS;
                    end else begin
                        stateNext = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (waitLast) begin
                    stateNext = ST_ACCESS;
                end
            end
            ST_ACCESS: stateNext = opWrite ? ST_RESP : ST_RDATA;
            ST_RDATA:  stateNext = ST_RESP;
            ST_RESP:   stateNext = ST_DRAIN;
            ST_DRAIN: begin
                if (!req) begin
                    stateNext = ST_IDLE;
                end
            end
            default:   stateNext = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Request latches, captured once when IDLE accepts a request.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            addrLatch  <= '0;
            wdataLatch <= '0;
            opWrite    <= 1'b0;
            errLatch   <= 1'b0;
        end else if (sampleReq) begin
            addrLatch  <=
                MEM_ACCESS_CTRL_ADDRESS_InBUS[ADDRWIDTH+1:2];
            wdataLatch <= MEM_ACCESS_CTRL_data_InBUS;
            opWrite    <= MEM_ACCESS_CTRL_WR_In;
            errLatch   <= reqErr;
        end
    end

    // Read data register, updated only when RAM data is valid.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            readData <= '0;
        end else if (state == ST_RDATA) begin
            readData <= MEM_ACCESS_CTRL_MEM_RDATA_InBUS;
        end
    end

    assign MEM_ACCESS_CTRL_ACK_Out   = (state == ST_RESP);
    assign MEM_ACCESS_CTRL_ERROR_Out = (state == ST_RESP) && errLatch;
    assign MEM_ACCESS_CTRL_BUSY_Out  = (state != ST_IDLE);
    assign MEM_ACCESS_CTRL_data_OutBUS = readData;

    assign MEM_ACCESS_CTRL_MEM_EN_Out = (state == ST_ACCESS);
    assign MEM_ACCESS_CTRL_MEM_WE_Out = (state == ST_ACCESS) && opWrite;
    assign MEM_ACCESS_CTRL_MEM_ADDR_OutBUS  = addrLatch;
    assign MEM_ACCESS_CTRL_MEM_WDATA_OutBUS = wdataLatch;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural word RAM.
// Cycle numbers count negedges after the request-sampling edge.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rstN;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic        busy;
    logic [31:0] dout;
    logic        memEn;
    logic        memWe;
    logic [9:0]  memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;

    logic [31:0] ram [0:1023];

    int passed = 0;
    int total  = 0;

    int          enCyc;
    int          enN;
    logic        enWe;
    logic [9:0]  enAddr;
    logic [31:0] enWd;
    int          ackCyc;
    int          ackN;
    logic        ackErr;
    logic [31:0] ackData;
    int          idleCyc;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .DATAWIDTH_BUS (32),
        .ADDRWIDTH     (10),
        .WAIT_STATES   (2)
    ) dut (
        .MEM_ACCESS_CTRL_CLOCK_50         (clk),
        .MEM_ACCESS_CTRL_RESET_InLow      (rstN),
        .MEM_ACCESS_CTRL_RD_In            (rd),
        .MEM_ACCESS_CTRL_WR_In            (wr),
        .MEM_ACCESS_CTRL_ADDRESS_InBUS    (addr),
        .MEM_ACCESS_CTRL_data_InBUS       (wdata),
        .MEM_ACCESS_CTRL_ACK_Out          (ack),
        .MEM_ACCESS_CTRL_ERROR_Out        (err),
        .MEM_ACCESS_CTRL_BUSY_Out         (busy),
        .MEM_ACCESS_CTRL_data_OutBUS      (dout),
        .MEM_ACCESS_CTRL_MEM_EN_Out       (memEn),
        .MEM_ACCESS_CTRL_MEM_WE_Out       (memWe),
        .MEM_ACCESS_CTRL_MEM_ADDR_OutBUS  (memAddr),
        .MEM_ACCESS_CTRL_MEM_WDATA_OutBUS (memWdata),
        .MEM_ACCESS_CTRL_MEM_RDATA_InBUS  (memRdata)
    );

    // Synchronous RAM: read data appears the cycle after an enable.
    always @(posedge clk) begin
        if (memEn) begin
            if (memWe) ram[memAddr] <= memWdata;
            memRdata <= ram[memAddr];
        end
    end

    task automatic issue(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
    endtask

    // Observe one transaction; drop the request hold cycles after ACK.
    task automatic runTxn(input int hold);
        int dropCyc;
        dropCyc = -1;
        enCyc = -1; enN = 0; enWe = 1'bx; enAddr = 'x; enWd = 'x;
        ackCyc = -1; ackN = 0; ackErr = 1'bx; ackData = 'x;
        idleCyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (memEn) begin
                if (enCyc < 0) begin
                    enCyc = c; enWe = memWe; enAddr = memAddr; enWd = memWdata;
                end
                enN++;
            end
            if (ack) begin
                if (ackCyc < 0) begin
                    ackCyc = c; ackErr = err; ackData = dout; dropCyc = c + hold;
                end
                ackN++;
            end
            if (c == dropCyc) begin
                rd = 1'b0; wr = 1'b0;
            end
            if (!busy && ackCyc > 0) begin
                idleCyc = c;
                break;
            end
        end
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic test_reset;
        rstN = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        total++; if (ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", ack); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if (memEn !== 1'b0) $display("FAIL rst_en: got %b want 0", memEn); else passed++;
        total++; if (dout !== 32'h0) $display("FAIL rst_dout: got %h want 0", dout); else passed++;
        total++; if (memAddr !== 10'h0) $display("FAIL rst_addr: got %h want 0", memAddr); else passed++;
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        issue(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        runTxn(0);
        total++; if (enCyc !== 3) $display("FAIL wr_en_cycle: got %0d want 3", enCyc); else passed++;
        total++; if (enN !== 1) $display("FAIL wr_en_count: got %0d want 1", enN); else passed++;
        total++; if (enWe !== 1'b1) $display("FAIL wr_we: got %b want 1", enWe); else passed++;
        total++; if (enAddr !== 10'd4) $display("FAIL wr_addr: got %0d want 4", enAddr); else passed++;
        total++; if (enWd !== 32'hDEAD_BEEF) $display("FAIL wr_wdata: got %h want deadbeef", enWd); else passed++;
        total++; if (ackCyc !== 4) $display("FAIL wr_ack_cycle: got %0d want 4", ackCyc); else passed++;
        total++; if (ackErr !== 1'b0) $display("FAIL wr_err: got %b want 0", ackErr); else passed++;
        total++; if (ackData !== 32'h0) $display("FAIL wr_dout_kept: got %h want 0", ackData); else passed++;
        total++; if (idleCyc !== 6) $display("FAIL wr_idle_cycle: got %0d want 6", idleCyc); else passed++;
    endtask

    task automatic test_read;
        issue(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        runTxn(0);
        total++; if (enCyc !== 3) $display("FAIL rd_en_cycle: got %0d want 3", enCyc); else passed++;
        total++; if (enN !== 1) $display("FAIL rd_en_count: got %0d want 1", enN); else passed++;
        total++; if (enWe !== 1'b0) $display("FAIL rd_we: got %b want 0", enWe); else passed++;
        total++; if (ackCyc !== 5) $display("FAIL rd_ack_cycle: got %0d want 5", ackCyc); else passed++;
        total++; if (ackData !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h want deadbeef", ackData); else passed++;
        total++; if (ackErr !== 1'b0) $display("FAIL rd_err: got %b want 0", ackErr); else passed++;
    endtask

    task automatic test_errors;
        issue(1'b1, 1'b0, 32'h0000_0012, 32'h0);
        runTxn(0);
        total++; if (ackCyc !== 1) $display("FAIL mis_ack_cycle: got %0d want 1", ackCyc); else passed++;
        total++; if (ackErr !== 1'b1) $display("FAIL mis_err: got %b want 1", ackErr); else passed++;
        total++; if (enN !== 0) $display("FAIL mis_en_count: got %0d want 0", enN); else passed++;
        total++; if (ackData !== 32'hDEAD_BEEF) $display("FAIL mis_dout_kept: got %h want deadbeef", ackData); else passed++;
        issue(1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111);
        runTxn(0);
        total++; if (ackCyc !== 1) $display("FAIL both_ack_cycle: got %0d want 1", ackCyc); else passed++;
        total++; if (ackErr !== 1'b1) $display("FAIL both_err: got %b want 1", ackErr); else passed++;
        total++; if (enN !== 0) $display("FAIL both_en_count: got %0d want 0", enN); else passed++;
        issue(1'b1, 1'b0, 32'h0000_1000, 32'h0);
        runTxn(0);
        total++; if (ackCyc !== 1) $display("FAIL oor_ack_cycle: got %0d want 1", ackCyc); else passed++;
        total++; if (ackErr !== 1'b1) $display("FAIL oor_err: got %b want 1", ackErr); else passed++;
        total++; if (enN !== 0) $display("FAIL oor_en_count: got %0d want 0", enN); else passed++;
        total++; if (ram[4] !== 32'hDEAD_BEEF) $display("FAIL err_ram_intact: got %h want deadbeef", ram[4]); else passed++;
    endtask

    task automatic test_held_read;
        issue(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        runTxn(3);
        total++; if (enN !== 1) $display("FAIL hold_en_count: got %0d want 1", enN); else passed++;
        total++; if (ackN !== 1) $display("FAIL hold_ack_count: got %0d want 1", ackN); else passed++;
        total++; if (ackCyc !== 5) $display("FAIL hold_ack_cycle: got %0d want 5", ackCyc); else passed++;
        total++; if (ackData !== 32'hDEAD_BEEF) $display("FAIL hold_data: got %h want deadbeef", ackData); else passed++;
        total++; if (idleCyc !== 9) $display("FAIL hold_idle_cycle: got %0d want 9", idleCyc); else passed++;
    endtask

    task automatic test_reset_mid;
        int stray;
        stray = 0;
        issue(1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D);
        @(negedge clk);
        if (memEn || ack) stray++;
        @(negedge clk);
        if (memEn || ack) stray++;
        rstN = 1'b0;
        @(negedge clk);
        total++; if (memEn !== 1'b0) $display("FAIL mid_en: got %b want 0", memEn); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
        total++; if (ack !== 1'b0) $display("FAIL mid_ack: got %b want 0", ack); else passed++;
        total++; if (dout !== 32'h0) $display("FAIL mid_dout: got %h want 0", dout); else passed++;
        total++; if (memWdata !== 32'h0) $display("FAIL mid_wdata: got %h want 0", memWdata); else passed++;
        total++; if (memAddr !== 10'h0) $display("FAIL mid_addr: got %h want 0", memAddr); else passed++;
        rstN = 1'b1; wr = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (memEn || ack) stray++;
        end
        total++; if (stray !== 0) $display("FAIL mid_stray: got %0d want 0", stray); else passed++;
    endtask

    task automatic test_back_to_back;
        issue(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678);
        runTxn(0);
        total++; if (enCyc !== 3) $display("FAIL b2b_wr_en_cycle: got %0d want 3", enCyc); else passed++;
        total++; if (enAddr !== 10'd16) $display("FAIL b2b_wr_addr: got %0d want 16", enAddr); else passed++;
        total++; if (ackCyc !== 4) $display("FAIL b2b_wr_ack_cycle: got %0d want 4", ackCyc); else passed++;
        issue(1'b0, 1'b1, 32'h0000_0FFC, 32'hA5A5_0001);
        runTxn(0);
        total++; if (enAddr !== 10'd1023) $display("FAIL b2b_top_addr: got %0d want 1023", enAddr); else passed++;
        total++; if (ackErr !== 1'b0) $display("FAIL b2b_top_err: got %b want 0", ackErr); else passed++;
        issue(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        runTxn(0);
        total++; if (ackData !== 32'h1234_5678) $display("FAIL b2b_rd1: got %h want 12345678", ackData); else passed++;
        issue(1'b1, 1'b0, 32'h0000_0FFC, 32'h0);
        runTxn(0);
        total++; if (ackData !== 32'hA5A5_0001) $display("FAIL b2b_rd2: got %h want a5a50001", ackData); else passed++;
        total++; if (ackCyc !== 5) $display("FAIL b2b_rd2_ack_cycle: got %0d want 5", ackCyc); else passed++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_held_read();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
